// File: rtl/alct_cfg_pkg.sv
// Shared definitions for the ALCT configuration blocks: mask geometry,
// the hot-channel mask safe value and the loader state encoding.
package alct_cfg_pkg;

   localparam int MASK_W = 384;
   localparam int WORD_W = 16;
   localparam int NWORDS = MASK_W / WORD_W;
   localparam int IDX_W  = 5;

   localparam logic [MASK_W-1:0] HCMASK_RESET = {MASK_W{1'b1}};

   typedef enum logic [1:0] {
      ST_IDLE,
      ST_LOAD,
      ST_WAIT_QUIET,
      ST_APPLY
   } hcm_state_t;

endpackage

// File: rtl/quiet_window_det.sv
// Quiet-window and timeout counters for the hot-channel mask commit.
// Both counters are held at zero whenever the loader is not waiting.
module quiet_window_det #(
   parameter int QUIET_CYC = 8,
   parameter int TMO_CYC   = 4096
) (
   input  logic clk,
   input  logic rst_n,
   input  logic en,
   input  logic actv_feb_fg,
   input  logic trig_stop,
   output logic commit_ok,
   output logic tmo
);

   localparam int QW = $clog2(QUIET_CYC + 1);
   localparam int TW = $clog2(TMO_CYC + 1);
   localparam logic [QW-1:0] QMAX = QW'(QUIET_CYC - 1);
   localparam logic [TW-1:0] TMAX = TW'(TMO_CYC - 1);

   logic [QW-1:0] quiet_cnt;
   logic [TW-1:0] tmo_cnt;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         quiet_cnt <= '0;
         tmo_cnt   <= '0;
      end else if (!en) begin
         quiet_cnt <= '0;
         tmo_cnt   <= '0;
      end else begin
         if (actv_feb_fg)
            quiet_cnt <= '0;
         else if (quiet_cnt != QMAX)
            quiet_cnt <= quiet_cnt + QW'(1);
         if (tmo_cnt != TMAX)
            tmo_cnt <= tmo_cnt + TW'(1);
      end
   end

   assign commit_ok = en & (trig_stop | (~actv_feb_fg & (quiet_cnt == QMAX)));
   assign tmo       = en & (tmo_cnt == TMAX);

endmodule

// File: rtl/hcmask_loader.sv
// Hot-channel mask loader: fills a shadow mask word by word, then swaps it
// into the live mask in a single edge once the trigger is quiet or stopped.
module hcmask_loader
   import alct_cfg_pkg::*;
#(
   parameter int QUIET_CYC = 8,
   parameter int TMO_CYC   = 4096
) (
   input  logic              clk,
   input  logic              rst_n,
   input  logic              cfg_start,
   input  logic              cfg_wr,
   input  logic [WORD_W-1:0] cfg_data,
   input  logic              cfg_abort,
   input  logic              actv_feb_fg,
   input  logic              trig_stop,
   input  logic [IDX_W-1:0]  rd_idx,
   output logic [WORD_W-1:0] rd_data,
   output logic [MASK_W-1:0] HCmask,
   output logic              cfg_busy,
   output logic              cfg_done,
   output logic              cfg_err
);

   hcm_state_t        state_q, state_d;
   logic [IDX_W-1:0]  idx_q, idx_d, wr_idx;
   logic [MASK_W-1:0] shadow;
   logic [WORD_W-1:0] rd_word;
   logic              wr_en, commit, err_d;
   logic              commit_ok, tmo;

   quiet_window_det #(
      .QUIET_CYC (QUIET_CYC),
      .TMO_CYC   (TMO_CYC)
   ) u_qwd (
      .clk         (clk),
      .rst_n       (rst_n),
      .en          (state_q == ST_WAIT_QUIET),
      .actv_feb_fg (actv_feb_fg),
      .trig_stop   (trig_stop),
      .commit_ok   (commit_ok),
      .tmo         (tmo)
   );

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) state_q <= ST_IDLE;
      else        state_q <= state_d;
   end

   always_comb begin
      state_d = state_q;
      idx_d   = idx_q;
      wr_idx  = idx_q;
      wr_en   = 1'b0;
      commit  = 1'b0;
      err_d   = 1'b0;
      if (cfg_abort) begin
         state_d = ST_IDLE;
      end else begin
         case (state_q)
            ST_IDLE: begin
               if (cfg_start) begin
                  state_d = ST_LOAD;
                  idx_d   = '0;
               end else if (cfg_wr) begin
                  err_d = 1'b1;
               end
            end
            ST_LOAD: begin
               // A restart coinciding with a write lands that write on word 0
               if (cfg_start) begin
                  wr_idx = '0;
                  idx_d  = '0;
               end
               if (cfg_wr) begin
                  wr_en = 1'b1;
                  if (wr_idx == IDX_W'(NWORDS - 1))
                     state_d = ST_WAIT_QUIET;
                  else
                     idx_d = wr_idx + IDX_W'(1);
               end
            end
            ST_WAIT_QUIET: begin
               if (commit_ok) begin
                  state_d = ST_APPLY;
                  commit  = 1'b1;
               end else if (tmo) begin
                  state_d = ST_IDLE;
                  err_d   = 1'b1;
               end
               if (cfg_wr) err_d = 1'b1;
            end
            ST_APPLY: state_d = ST_IDLE;
            default:  state_d = ST_IDLE;
         endcase
      end
   end

   always_comb begin
      rd_word = '0;
      for (int k = 0; k < NWORDS; k++)
         if (rd_idx == IDX_W'(k)) rd_word = HCmask[k*WORD_W +: WORD_W];
   end

   // Live mask is loaded on the edge that leaves WAIT_QUIET, so APPLY is
   // the first cycle the trigger logic sees the complete new mask.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         idx_q   <= '0;
         shadow  <= HCMASK_RESET;
         HCmask  <= HCMASK_RESET;
         cfg_err <= 1'b0;
         rd_data <= '0;
      end else begin
         idx_q   <= idx_d;
         cfg_err <= err_d;
         rd_data <= rd_word;
         if (wr_en)  shadow[int'(wr_idx)*WORD_W +: WORD_W] <= cfg_data;
         if (commit) HCmask <= shadow;
      end
   end

   assign cfg_busy = (state_q != ST_IDLE);
   assign cfg_done = (state_q == ST_APPLY);

endmodule
